mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported synchronous memory between the fetch stage (instruction reads)
//  and the memory_access stage (data loads/stores) of the 5-stage CPU.
//  - Grants at most one request per cycle.
//  - Tracks in-flight reads and returns each read to its owner after a fixed latency.
//  - Data has priority; a starvation guard ensures fetch always makes progress.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width (wstrb width = DATA_W/8)
//  MEM_LAT     1   cycles from mem_en to mem_rdata valid; legal range 1..4
//  STARVE_MAX  4   consecutive denied fetch cycles before fetch is forced; legal range >=1
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          asynchronous, active-low reset
//  i_req_valid   in   1          fetch read request
//  i_req_addr    in   ADDR_W     fetch address
//  i_req_ready   out  1          fetch request granted this cycle
//  i_rsp_valid   out  1          fetch read data valid
//  i_rsp_data    out  DATA_W     fetch read data
//  d_req_valid   in   1          data request
//  d_req_we      in   1          1 = store, 0 = load
//  d_req_wstrb   in   DATA_W/8   store byte enables
//  d_req_addr    in   ADDR_W     data address
//  d_req_wdata   in   DATA_W     store data
//  d_req_ready   out  1          data request granted this cycle
//  d_rsp_valid   out  1          load data valid (stores return no response)
//  d_rsp_data    out  DATA_W     load data
//  flush         in   1          fetch redirect; kill in-flight fetch reads
//  mem_en        out  1          memory access strobe
//  mem_we        out  1          memory write enable
//  mem_wstrb     out  DATA_W/8   memory byte enables
//  mem_addr      out  ADDR_W     memory address
//  mem_wdata     out  DATA_W     memory write data
//  mem_rdata     in   DATA_W     memory read data, valid MEM_LAT cycles after mem_en
//  busy          out  1          any read in flight
//  perf_i_cnt    out  32         fetch grant count (see CONFIGURATION)
//  perf_d_cnt    out  32         data grant count
//  perf_cf_cnt   out  32         conflict-cycle count
// BEHAVIOUR
//  Reset values:
//  - All outputs are 0.
//  - state = ST_DPRI, starve_cnt = 0, tag pipe empty.
//  Grant (combinational from current inputs and state):
//  - ST_DPRI:   grant_d = d_req_valid; grant_i = i_req_valid & ~d_req_valid.
//  - ST_IFORCE: grant_i = i_req_valid; grant_d = d_req_valid & ~i_req_valid.
//  - ready = grant. mem_en = grant_i | grant_d. The mem_* fields mux from the granted requester.
//  - mem_we = grant_d & d_req_we. When grant_i, mem_wstrb = 0.
//  - A request is accepted only on valid & ready. Requesters hold their fields until ready.
//  Starvation counter:
//  - starve_cnt++ (saturating at STARVE_MAX) on any cycle with i_req_valid & ~grant_i.
//  - starve_cnt is cleared on grant_i or when i_req_valid = 0.
//  FSM transitions:
//  - ST_DPRI -> ST_IFORCE when the next starve_cnt value equals STARVE_MAX.
//  - ST_IFORCE -> ST_DPRI after a cycle with grant_i, or when i_req_valid = 0.
//  Tag pipe:
//  - MEM_LAT stages of {vld, own, kill}.
//  - Stage 0 loads vld = mem_en & ~mem_we, own = grant_d, kill = 0.
//  - The output stage drives the responses:
//    - i_rsp_valid = vld & ~own & ~kill
//    - d_rsp_valid = vld & own
//    - both response data ports = mem_rdata
//  - Responses are never back-pressured.
//  Flush:
//  - Sets kill on every in-flight fetch tag in the same cycle.
//  - A fetch granted in the flush cycle is still issued and is not killed; fetch must drop i_req_valid itself.
//  - flush never affects data tags.
//  Simultaneous requests: both valid -> exactly one grant. Never two grants; never a grant with valid = 0.
//  Back-to-back: one new grant every cycle. With N reads in flight, busy = 1.
//  Reset mid-operation clears all tags. Outstanding reads produce no response.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined:
//  - perf_i_cnt += grant_i.
//  - perf_d_cnt += grant_d.
//  - perf_cf_cnt += (i_req_valid & d_req_valid).
//  - 32-bit counters, wrap modulo 2^32, cleared by reset.
//  ARB_PERF_CNT_EN undefined: the perf_* ports are tied to 0 and no counter flops are built.
// STRUCTURE
//  define.v holds ARB_ST_DPRI=1'b0, ARB_ST_IFORCE=1'b1, ARB_OWN_I=1'b0, ARB_OWN_D=1'b1.
//  Sub-module arb_tag_pipe (parameter MEM_LAT):
//  - Shift register of {vld, own, kill}.
//  - Has a kill_i input that marks all fetch entries.
//  The arbiter FSM, starvation counter and perf counters stay in the top level.
// TESTING
//  1. Fetch only, addr 0x0,0x4,0x8 on consecutive cycles, MEM_LAT=1
//     -> three grants; i_rsp_valid on cycles 1..3 with matching data.
//  2. Both valid every cycle, STARVE_MAX=4
//     -> 4 data grants, 1 fetch grant, repeating; perf_cf_cnt = cycle count.
//  3. Load at 0x100 then store at 0x104 with wstrb=4'b0011
//     -> d_rsp_valid once only; memory bytes [1:0] of 0x104 updated.
//  4. MEM_LAT=3, two fetch reads in flight, flush asserted
//     -> neither produces i_rsp_valid; a data load issued alongside still returns.
//  5. rst asserted low with 2 reads in flight
//     -> all outputs 0 immediately; no responses after release; state = ST_DPRI.
//  6. Build without ARB_PERF_CNT_EN -> perf_* stay 0 throughout scenario 2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, tag owner
// encoding and the in-flight read tag carried by the tag pipe.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ST_DPRI   = 1'b0,
        ST_IFORCE = 1'b1
    } arb_state_e;

    localparam logic ARB_OWN_I = 1'b0;
    localparam logic ARB_OWN_D = 1'b1;

    typedef struct packed {
        logic vld;
        logic own;
        logic kill;
    } arb_tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Tag pipe: one {vld, own, kill} entry per cycle of memory latency. The last
// stage lines up with mem_rdata and tells the top which port the data is for.
// kill_i marks every in-flight fetch entry; data entries are never touched.
module arb_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     vld_i,
    input  logic     own_i,
    input  logic     kill_i,
    output arb_tag_t out_o,
    output logic     busy_o
);

    arb_tag_t [MEM_LAT-1:0] tag_q, tag_d;

    // Shift tags one stage per cycle, marking fetch entries dead on kill_i.
    always_comb begin
        tag_d         = '0;
        tag_d[0].vld  = vld_i;
        tag_d[0].own  = own_i;
        tag_d[0].kill = 1'b0;
        for (int k = 1; k < MEM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
            if (kill_i && tag_q[k-1].vld && (tag_q[k-1].own == ARB_OWN_I))
                tag_d[k].kill = 1'b1;
        end
    end

    // Tag storage; reset drops every outstanding read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tag_q <= '0;
        else      tag_q <= tag_d;
    end

    // Busy while any stage holds a read, killed or not.
    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < MEM_LAT; k++) busy_o = busy_o | tag_q[k].vld;
    end

    assign out_o = tag_q[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-ported synchronous memory between
// instruction fetch and data access. Data wins by default; after STARVE_MAX
// consecutive denied fetch cycles the FSM forces one fetch grant.
// Optional feature: define ARB_PERF_CNT_EN to build the grant/conflict
// counters; otherwise perf_* read as 0 and no counter flops exist.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_req_ready,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rsp_data,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    input  logic                flush,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic [31:0]         perf_i_cnt,
    output logic [31:0]         perf_d_cnt,
    output logic [31:0]         perf_cf_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          grant_i, grant_d;
    arb_tag_t      tag_out;

    // Grant selection: priority flips to fetch only in ST_IFORCE.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == ST_DPRI) begin
            grant_d = d_req_valid;
            grant_i = i_req_valid & ~d_req_valid;
        end else begin
            grant_i = i_req_valid;
            grant_d = d_req_valid & ~i_req_valid;
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    // Memory request mux; idle fields are zero and fetch never carries strobes.
    always_comb begin
        mem_en    = grant_i | grant_d;
        mem_we    = grant_d & d_req_we;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_wstrb = d_req_wstrb;
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
        end else if (grant_i) begin
            mem_addr  = i_req_addr;
        end
    end

    // Starvation count and the priority state it drives.
    always_comb begin
        starve_d = starve_q;
        if (!i_req_valid || grant_i)   starve_d = '0;
        else if (starve_q < STARVE_LIM) starve_d = starve_q + SW'(1);

        state_d = state_q;
        case (state_q)
            ST_DPRI:   if (starve_d == STARVE_LIM)     state_d = ST_IFORCE;
            ST_IFORCE: if (grant_i || !i_req_valid)    state_d = ST_DPRI;
            default:                                   state_d = ST_DPRI;
        endcase
    end

    // Arbiter FSM and starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_DPRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (mem_en & ~mem_we),
        .own_i  (grant_d),
        .kill_i (flush),
        .out_o  (tag_out),
        .busy_o (busy)
    );

    assign i_rsp_valid = tag_out.vld & (tag_out.own == ARB_OWN_I) & ~tag_out.kill;
    assign d_rsp_valid = tag_out.vld & (tag_out.own == ARB_OWN_D);
    // Read data is zeroed when no response is presented so idle outputs are 0.
    assign i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
    assign d_rsp_data  = d_rsp_valid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_cf_q, perf_cf_d;

    // Free-running grant and conflict counters, wrapping modulo 2^32.
    always_comb begin
        perf_i_d  = perf_i_q  + {31'd0, grant_i};
        perf_d_d  = perf_d_q  + {31'd0, grant_d};
        perf_cf_d = perf_cf_q + {31'd0, i_req_valid & d_req_valid};
    end

    // Counter storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_i_q  <= '0;
            perf_d_q  <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_i_q  <= perf_i_d;
            perf_d_q  <= perf_d_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_i_cnt  = perf_i_q;
    assign perf_d_cnt  = perf_d_q;
    assign perf_cf_cnt = perf_cf_q;
`else
    assign perf_i_cnt  = '0;
    assign perf_d_cnt  = '0;
    assign perf_cf_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share the request
// inputs: u_dut_a with MEM_LAT=1 and u_dut_b with MEM_LAT=3, each backed by
// its own small memory model whose word i initially holds 0xA000_0000 + i.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic [31:0] i_req_addr  = '0;
    logic        d_req_valid = 1'b0;
    logic        d_req_we    = 1'b0;
    logic [3:0]  d_req_wstrb = '0;
    logic [31:0] d_req_addr  = '0;
    logic [31:0] d_req_wdata = '0;
    logic        flush       = 1'b0;

    logic        i_req_ready_a, i_rsp_valid_a, d_req_ready_a, d_rsp_valid_a;
    logic [31:0] i_rsp_data_a, d_rsp_data_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        mem_en_a, mem_we_a, busy_a;
    logic [3:0]  mem_wstrb_a;
    logic [31:0] perf_i_a, perf_d_a, perf_cf_a;

    logic        i_req_ready_b, i_rsp_valid_b, d_req_ready_b, d_rsp_valid_b;
    logic [31:0] i_rsp_data_b, d_rsp_data_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        mem_en_b, mem_we_b, busy_b;
    logic [3:0]  mem_wstrb_b;
    logic [31:0] perf_i_b, perf_d_b, perf_cf_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready_a),
        .i_rsp_valid(i_rsp_valid_a), .i_rsp_data(i_rsp_data_a),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready_a),
        .d_rsp_valid(d_rsp_valid_a), .d_rsp_data(d_rsp_data_a),
        .flush(flush),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_wstrb(mem_wstrb_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .perf_i_cnt(perf_i_a), .perf_d_cnt(perf_d_a), .perf_cf_cnt(perf_cf_a)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready_b),
        .i_rsp_valid(i_rsp_valid_b), .i_rsp_data(i_rsp_data_b),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready_b),
        .d_rsp_valid(d_rsp_valid_b), .d_rsp_data(d_rsp_data_b),
        .flush(flush),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_wstrb(mem_wstrb_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .perf_i_cnt(perf_i_b), .perf_d_cnt(perf_d_b), .perf_cf_cnt(perf_cf_b)
    );

    // Memory models: latency 1 for dut_a, latency 3 for dut_b.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a;
    logic [31:0] rd_b [3];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'hA000_0000 + i;
            mem_b[i] = 32'hA000_0000 + i;
        end
    end

    always @(posedge clk) begin
        if (mem_en_a) begin
            if (mem_we_a) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb_a[b]) mem_a[mem_addr_a[9:2]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
            end else begin
                rd_a <= mem_a[mem_addr_a[9:2]];
            end
        end
    end
    assign mem_rdata_a = rd_a;

    always @(posedge clk) begin
        if (mem_en_b && mem_we_b) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb_b[b]) mem_b[mem_addr_b[9:2]][8*b +: 8] <= mem_wdata_b[8*b +: 8];
        end
        rd_b[0] <= (mem_en_b && !mem_we_b) ? mem_b[mem_addr_b[9:2]] : 32'hDEAD_BEEF;
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign mem_rdata_b = rd_b[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        i_req_valid = 1'b0; i_req_addr  = '0;
        d_req_valid = 1'b0; d_req_we    = 1'b0; d_req_wstrb = '0;
        d_req_addr  = '0;   d_req_wdata = '0;   flush       = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet_b(input string tag);
        chk({tag, "_ctl"}, {26'd0, i_req_ready_b, d_req_ready_b, i_rsp_valid_b,
                             d_rsp_valid_b, mem_en_b, busy_b}, 32'd0);
        chk({tag, "_idat"}, i_rsp_data_b, 32'd0);
        chk({tag, "_ddat"}, d_rsp_data_b, 32'd0);
        chk({tag, "_perf"}, perf_i_b | perf_d_b | perf_cf_b, 32'd0);
    endtask

    logic [31:0] exp_pi, exp_pd, exp_pcf;

    initial begin
        // Reset state
        idle_in();
        #2;
        chk("rst_a_ctl", {26'd0, i_req_ready_a, d_req_ready_a, i_rsp_valid_a,
                          d_rsp_valid_a, mem_en_a, busy_a}, 32'd0);
        chk_quiet_b("rst_b");
        next_cyc(); next_cyc();
        rst = 1'b1;

        // Fetch only, three back-to-back reads, MEM_LAT=1; data strobes must not leak
        for (int k = 0; k < 4; k++) begin
            idle_in();
            d_req_wstrb = 4'hF;
            if (k < 3) begin i_req_valid = 1'b1; i_req_addr = 32'(4 * k); end
            @(negedge clk);
            chk("t1_irsp_v", {31'd0, i_rsp_valid_a}, {31'd0, k >= 1});
            if (k < 3) begin
                chk("t1_iready", {31'd0, i_req_ready_a}, 32'd1);
                chk("t1_maddr", mem_addr_a, 32'(4 * k));
                chk("t1_wstrb", {28'd0, mem_wstrb_a}, 32'd0);
            end
            if (k >= 1) chk("t1_irsp_d", i_rsp_data_a, 32'hA000_0000 + 32'(k - 1));
            next_cyc();
        end
        idle_in();
        @(negedge clk);
        chk("t1_idle_busy", {31'd0, busy_a}, 32'd0);
        next_cyc();

        // Both valid every cycle: 4 data grants then 1 forced fetch grant
        for (int k = 0; k < 10; k++) begin
            idle_in();
            i_req_valid = 1'b1; i_req_addr = 32'h40;
            d_req_valid = 1'b1; d_req_addr = 32'h80;
            @(negedge clk);
            chk("t2_igrant", {31'd0, i_req_ready_a}, {31'd0, (k % 5) == 4});
            chk("t2_dgrant", {31'd0, d_req_ready_a}, {31'd0, (k % 5) != 4});
            next_cyc();
        end
        idle_in();
        @(negedge clk);
`ifdef ARB_PERF_CNT_EN
        exp_pi = 32'd5; exp_pd = 32'd8; exp_pcf = 32'd10;
`else
        exp_pi = 32'd0; exp_pd = 32'd0; exp_pcf = 32'd0;
`endif
        chk("t2_perf_i", perf_i_a, exp_pi);
        chk("t2_perf_d", perf_d_a, exp_pd);
        chk("t2_perf_cf", perf_cf_a, exp_pcf);
        for (int k = 0; k < 4; k++) next_cyc();

        // Load 0x100, store 0x104 low halfword, read 0x104 back
        for (int k = 0; k < 5; k++) begin
            idle_in();
            case (k)
                0: begin d_req_valid = 1'b1; d_req_addr = 32'h100; end
                1: begin d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h104;
                         d_req_wstrb = 4'b0011; d_req_wdata = 32'h1122_3344; end
                2: begin d_req_valid = 1'b1; d_req_addr = 32'h104; end
                default: ;
            endcase
            @(negedge clk);
            chk("t3_drsp_v", {31'd0, d_rsp_valid_a}, {31'd0, k == 1 || k == 3});
            chk("t3_irsp_v", {31'd0, i_rsp_valid_a}, 32'd0);
            if (k == 0) chk("t3_ld_we", {31'd0, mem_we_a}, 32'd0);
            if (k == 1) begin
                chk("t3_ld_data", d_rsp_data_a, 32'hA000_0040);
                chk("t3_st_ctl", {mem_we_a, mem_wstrb_a, mem_addr_a[26:0]}, {1'b1, 4'b0011, 27'h104});
                chk("t3_st_wdata", mem_wdata_a, 32'h1122_3344);
            end
            if (k == 3) chk("t3_rb_data", d_rsp_data_a, 32'hA000_3344);
            next_cyc();
        end
        for (int k = 0; k < 3; k++) next_cyc();

        // MEM_LAT=3: two fetches killed by flush, load alongside survives,
        // then a fetch granted in a flush cycle still returns
        for (int k = 0; k < 12; k++) begin
            idle_in();
            case (k)
                0: begin i_req_valid = 1'b1; i_req_addr = 32'h10; end
                1: begin i_req_valid = 1'b1; i_req_addr = 32'h14; end
                2: begin flush = 1'b1; d_req_valid = 1'b1; d_req_addr = 32'h200; end
                7: begin flush = 1'b1; i_req_valid = 1'b1; i_req_addr = 32'h18; end
                default: ;
            endcase
            @(negedge clk);
            chk("t4_irsp_v", {31'd0, i_rsp_valid_b}, {31'd0, k == 10});
            chk("t4_drsp_v", {31'd0, d_rsp_valid_b}, {31'd0, k == 5});
            if (k == 2)  chk("t4_busy", {31'd0, busy_b}, 32'd1);
            if (k == 5)  chk("t4_ld_data", d_rsp_data_b, 32'hA000_0080);
            if (k == 7)  chk("t4_fl_grant", {31'd0, i_req_ready_b}, 32'd1);
            if (k == 10) chk("t4_fl_data", i_rsp_data_b, 32'hA000_0006);
            next_cyc();
        end

        // Reset with a fetch and a load in flight on the MEM_LAT=3 instance
        idle_in();
        i_req_valid = 1'b1; i_req_addr = 32'h20;
        next_cyc();
        idle_in();
        d_req_valid = 1'b1; d_req_addr = 32'h24;
        next_cyc();
        idle_in();
        @(negedge clk);
        chk("t5_busy", {31'd0, busy_b}, 32'd1);
        #1 rst = 1'b0;
        #1 chk_quiet_b("t5_inrst");
        next_cyc();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle_in();
            if (k == 0) begin
                i_req_valid = 1'b1; i_req_addr = 32'h30;
                d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'h0; d_req_addr = 32'h300;
            end
            @(negedge clk);
            chk("t5_irsp_v", {31'd0, i_rsp_valid_b}, 32'd0);
            chk("t5_drsp_v", {31'd0, d_rsp_valid_b}, 32'd0);
            if (k == 0) begin
                chk("t5_dpri_d", {31'd0, d_req_ready_b}, 32'd1);
                chk("t5_dpri_i", {31'd0, i_req_ready_b}, 32'd0);
            end
            next_cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
